// File: rtl/pic_pkg.sv
// Shared types and constants for the programmable interrupt controller.
package pic_pkg;

  typedef enum logic [1:0] {
    INIT_UNINIT,
    INIT_WAIT_ICW2,
    INIT_WAIT_ICW4,
    INIT_READY
  } init_state_t;

  typedef enum logic [1:0] {
    INTA_IDLE,
    INTA_ACK1,
    INTA_ACK2
  } inta_state_t;

  // OCW2 command field D7:5 = {R, SL, EOI}
  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_EOI          = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SEOI         = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_EOI      = 3'b101;
  localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
  localparam logic [2:0] OCW2_ROT_SEOI     = 3'b111;

  localparam logic [1:0] ADDR_CMD  = 2'd0;
  localparam logic [1:0] ADDR_DATA = 2'd1;
  localparam logic [1:0] ADDR_IMRH = 2'd2;
  localparam logic [1:0] ADDR_OCW2 = 2'd3;

endpackage

// File: rtl/pic_if.sv
// CPU-side register bus and INTA handshake of the interrupt controller.
interface pic_if;
  logic [1:0] A;
  logic [7:0] DIN;
  logic       WR;
  logic       RD;
  logic [7:0] DOUT;
  logic       DOUT_EN;
  logic       INTA_;
  logic       INT;

  modport master (
    output A, DIN, WR, RD, INTA_,
    input  DOUT, DOUT_EN, INT
  );

  modport slave (
    input  A, DIN, WR, RD, INTA_,
    output DOUT, DOUT_EN, INT
  );
endinterface

// File: rtl/pic_priority_resolver.sv
// Combinational rotating-priority arbiter with fully nested blocking by the ISR.
module pic_priority_resolver
  import pic_pkg::*;
#(
  parameter int unsigned NUM_IR = 8,
  localparam int unsigned IDW = $clog2(NUM_IR)
) (
  input  logic [NUM_IR-1:0] req,
  input  logic [NUM_IR-1:0] mask,
  input  logic [NUM_IR-1:0] isr,
  input  logic [IDW-1:0]    lp,
  output logic              valid,
  output logic [IDW-1:0]    id,
  output logic [IDW-1:0]    top_isr_id
);

  logic [IDW-1:0] idx;
  logic [IDW-1:0] req_rank;
  logic [IDW-1:0] isr_rank;
  logic           req_found;
  logic           isr_found;

  // Walk ranks from highest (just after LP) downward; first hit wins.
  always_comb begin
    valid      = 1'b0;
    id         = '0;
    top_isr_id = '0;
    idx        = '0;
    req_rank   = '0;
    isr_rank   = '0;
    req_found  = 1'b0;
    isr_found  = 1'b0;
    for (int unsigned r = 0; r < NUM_IR; r++) begin
      idx = lp + IDW'(1) + IDW'(r);
      if (!isr_found && isr[idx]) begin
        isr_found  = 1'b1;
        top_isr_id = idx;
        isr_rank   = IDW'(r);
      end
      if (!req_found && req[idx] && !mask[idx]) begin
        req_found = 1'b1;
        id        = idx;
        req_rank  = IDW'(r);
      end
    end
    valid = req_found && (!isr_found || (req_rank < isr_rank));
  end

endmodule

// File: rtl/pic_controller.sv
// Programmable interrupt controller: IR synchronisation, IRR/ISR/IMR,
// ICW/OCW register interface and the two-pulse INTA vector handshake.
module pic_controller
  import pic_pkg::*;
#(
  parameter int unsigned NUM_IR      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RESET_,
  input  logic [NUM_IR-1:0] IR,
  pic_if.slave              bus,
  output logic              INIT_DONE
);

  localparam int unsigned IDW = $clog2(NUM_IR);

  init_state_t init_q, init_next;
  inta_state_t inta_q, inta_next;

  logic [SYNC_STAGES:0][NUM_IR-1:0] ir_pipe;
  logic [SYNC_STAGES:0]             inta_pipe;
  logic [NUM_IR-1:0] ir_s, ir_rise;
  logic              inta_fall, inta_rise;

  logic [NUM_IR-1:0] irr_q, isr_q, imr_q;
  logic [NUM_IR-1:0] isr_set, isr_clr, irr_clr, imr_hi_wr;
  logic [IDW-1:0]    lp_q, lp_next;
  logic [IDW-1:0]    id_q;
  logic              spur_q;
  logic              ltim_q, ic4_q, aeoi_q, rot_aeoi_q, sel_isr_q;
  logic [7-IDW:0]    vbase_q;
  logic [7:0]        dout_q, rdata;
  logic              dout_en_q, int_q;
  logic [7:0]        irr_hi, isr_hi, imr_hi;

  logic              icw1, ready, ocw3_wr, data_wr, imrh_wr, ocw2_wr;
  logic [2:0]        ocw2_cmd;
  logic [IDW-1:0]    ocw2_lvl;
  logic              ack1, ack2, ack_end;
  logic              cand_valid, cand_ok;
  logic [IDW-1:0]    cand_id, top_isr_id;

  assign ir_s      = ir_pipe[SYNC_STAGES-1];
  assign ir_rise   = ir_pipe[SYNC_STAGES-1] & ~ir_pipe[SYNC_STAGES];
  assign inta_fall = !inta_pipe[SYNC_STAGES-1] && inta_pipe[SYNC_STAGES];
  assign inta_rise = inta_pipe[SYNC_STAGES-1] && !inta_pipe[SYNC_STAGES];

  assign ready    = (init_q == INIT_READY);
  assign icw1     = bus.WR && (bus.A == ADDR_CMD) && bus.DIN[4];
  assign ocw3_wr  = bus.WR && (bus.A == ADDR_CMD) && !bus.DIN[4] && ready;
  assign data_wr  = bus.WR && (bus.A == ADDR_DATA);
  assign imrh_wr  = bus.WR && (bus.A == ADDR_IMRH) && ready;
  assign ocw2_wr  = bus.WR && (bus.A == ADDR_OCW2) && ready;
  assign ocw2_cmd = bus.DIN[7:5];
  assign ocw2_lvl = bus.DIN[IDW-1:0];

  assign cand_ok = cand_valid && ready;
  assign ack1    = (inta_q == INTA_IDLE) && inta_fall && !icw1;
  assign ack2    = (inta_q == INTA_ACK1) && inta_fall && !icw1;
  assign ack_end = (inta_q == INTA_ACK2) && inta_rise && !icw1;

  assign INIT_DONE   = ready;
  assign bus.DOUT    = dout_q;
  assign bus.DOUT_EN = dout_en_q;
  assign bus.INT     = int_q;

  pic_priority_resolver #(.NUM_IR(NUM_IR)) u_resolver (
    .req        (irr_q),
    .mask       (imr_q),
    .isr        (isr_q),
    .lp         (lp_q),
    .valid      (cand_valid),
    .id         (cand_id),
    .top_isr_id (top_isr_id)
  );

  // Upper-byte views exist only in the 16-line build; the 8-line build reads zero.
  if (NUM_IR == 16) begin : g_wide
    assign irr_hi = irr_q[15:8];
    assign isr_hi = isr_q[15:8];
    assign imr_hi = imr_q[15:8];
    always_comb begin
      imr_hi_wr       = imr_q;
      imr_hi_wr[15:8] = bus.DIN;
    end
  end else begin : g_narrow
    assign irr_hi    = '0;
    assign isr_hi    = '0;
    assign imr_hi    = '0;
    assign imr_hi_wr = imr_q;
  end

  // IR and INTA_ synchronisers plus one extra stage for edge detection.
  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      ir_pipe   <= '0;
      inta_pipe <= '1;
    end else begin
      ir_pipe   <= {ir_pipe[SYNC_STAGES-1:0], IR};
      inta_pipe <= {inta_pipe[SYNC_STAGES-1:0], bus.INTA_};
    end
  end

  // Init and INTA state registers.
  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      init_q <= INIT_UNINIT;
      inta_q <= INTA_IDLE;
    end else begin
      init_q <= init_next;
      inta_q <= inta_next;
    end
  end

  // Init sequencing: ICW1 restarts from anywhere, A=1 writes advance.
  always_comb begin
    init_next = init_q;
    if (icw1) begin
      init_next = INIT_WAIT_ICW2;
    end else if (data_wr) begin
      case (init_q)
        INIT_WAIT_ICW2: init_next = ic4_q ? INIT_WAIT_ICW4 : INIT_READY;
        INIT_WAIT_ICW4: init_next = INIT_READY;
        default:        init_next = init_q;
      endcase
    end
  end

  // INTA handshake sequencing; ICW1 aborts any sequence in progress.
  always_comb begin
    inta_next = inta_q;
    case (inta_q)
      INTA_IDLE: if (inta_fall) inta_next = INTA_ACK1;
      INTA_ACK1: if (inta_fall) inta_next = INTA_ACK2;
      INTA_ACK2: if (inta_rise) inta_next = INTA_IDLE;
      default:   inta_next = INTA_IDLE;
    endcase
    if (icw1) inta_next = INTA_IDLE;
  end

  // Configuration registers written through ICWs and OCW3/OCW2.
  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      ltim_q     <= 1'b0;
      ic4_q      <= 1'b0;
      aeoi_q     <= 1'b0;
      rot_aeoi_q <= 1'b0;
      sel_isr_q  <= 1'b0;
      vbase_q    <= '0;
    end else if (icw1) begin
      ltim_q     <= bus.DIN[3];
      ic4_q      <= bus.DIN[0];
      aeoi_q     <= 1'b0;
      rot_aeoi_q <= 1'b0;
      sel_isr_q  <= 1'b0;
    end else begin
      if (data_wr && (init_q == INIT_WAIT_ICW2)) vbase_q <= bus.DIN[7:IDW];
      if (data_wr && (init_q == INIT_WAIT_ICW4)) aeoi_q  <= bus.DIN[1];
      if (ocw3_wr && bus.DIN[1]) sel_isr_q <= bus.DIN[0];
      if (ocw2_wr && (ocw2_cmd == OCW2_ROT_AEOI_SET)) rot_aeoi_q <= 1'b1;
      if (ocw2_wr && (ocw2_cmd == OCW2_ROT_AEOI_CLR)) rot_aeoi_q <= 1'b0;
    end
  end

  // ISR set/clear masks and LP update; sets are OR-ed in last so they win.
  always_comb begin
    isr_set = '0;
    isr_clr = '0;
    irr_clr = '0;
    lp_next = lp_q;
    if (ack1 && cand_ok) begin
      isr_set[cand_id] = 1'b1;
      irr_clr[cand_id] = 1'b1;
    end
    if (ocw2_wr && (|isr_q)) begin
      case (ocw2_cmd)
        OCW2_EOI:      isr_clr[top_isr_id] = 1'b1;
        OCW2_SEOI:     isr_clr[ocw2_lvl] = 1'b1;
        OCW2_ROT_EOI: begin
          isr_clr[top_isr_id] = 1'b1;
          lp_next             = top_isr_id;
        end
        OCW2_ROT_SEOI: begin
          isr_clr[ocw2_lvl] = 1'b1;
          lp_next           = ocw2_lvl;
        end
        default: ;
      endcase
    end
    if (ocw2_wr && (ocw2_cmd == OCW2_SET_PRI)) lp_next = ocw2_lvl;
    if (ack_end && aeoi_q && !spur_q) begin
      isr_clr[id_q] = 1'b1;
      if (rot_aeoi_q) lp_next = id_q;
    end
  end

  // Request, in-service, mask and lowest-priority registers.
  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      irr_q <= '0;
      isr_q <= '0;
      imr_q <= '0;
      lp_q  <= '1;
    end else if (icw1) begin
      irr_q <= '0;
      isr_q <= '0;
      imr_q <= '0;
      lp_q  <= '1;
    end else begin
      irr_q <= ltim_q ? ir_s : ((irr_q & ~irr_clr) | ir_rise);
      isr_q <= (isr_q & ~isr_clr) | isr_set;
      lp_q  <= lp_next;
      if (ready && data_wr) imr_q[7:0] <= bus.DIN;
      else if (imrh_wr)     imr_q      <= imr_hi_wr;
    end
  end

  // Frozen vector id and spurious flag captured at ACK1.
  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      id_q   <= '0;
      spur_q <= 1'b0;
    end else if (ack1) begin
      id_q   <= cand_ok ? cand_id : '1;
      spur_q <= !cand_ok;
    end
  end

  // Register read multiplexer.
  always_comb begin
    rdata = '0;
    case (bus.A)
      ADDR_CMD:  rdata = sel_isr_q ? isr_q[7:0] : irr_q[7:0];
      ADDR_DATA: rdata = imr_q[7:0];
      ADDR_IMRH: rdata = imr_hi;
      ADDR_OCW2: rdata = sel_isr_q ? isr_hi : irr_hi;
      default:   rdata = '0;
    endcase
  end

  // Output data: vector owns DOUT from ACK2 until INTA_ rises, else register reads.
  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      dout_q    <= '0;
      dout_en_q <= 1'b0;
    end else if (icw1) begin
      dout_q    <= '0;
      dout_en_q <= 1'b0;
    end else if (ack2) begin
      dout_q    <= {vbase_q, id_q};
      dout_en_q <= 1'b1;
    end else if (inta_q == INTA_ACK2) begin
      if (inta_rise) begin
        dout_q    <= '0;
        dout_en_q <= 1'b0;
      end
    end else if (bus.RD) begin
      dout_q    <= rdata;
      dout_en_q <= 1'b1;
    end else begin
      dout_q    <= '0;
      dout_en_q <= 1'b0;
    end
  end

  // INT follows the next-cycle state so it drops as soon as ACK1 is taken.
  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      int_q <= 1'b0;
    end else begin
      int_q <= !icw1 && (init_next == INIT_READY) && (inta_next == INTA_IDLE) && cand_valid;
    end
  end

endmodule

// File: tb/tb_pic_controller.sv
// Directed scoreboard bench for pic_controller (8- and 16-line builds).
module tb_pic_controller;

  logic        CLK = 1'b0;
  logic        RESET_;
  logic [7:0]  ir8;
  logic [15:0] ir16;
  logic [1:0]  a;
  logic [7:0]  din;
  logic        wr, rd, inta_n;
  logic        init_done8, init_done16;

  logic [7:0]  v8, v16, d8, d16;
  logic        e8, e16;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t        sb[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  pic_if bus8();
  pic_if bus16();

  assign bus8.A      = a;
  assign bus8.DIN    = din;
  assign bus8.WR     = wr;
  assign bus8.RD     = rd;
  assign bus8.INTA_  = inta_n;
  assign bus16.A     = a;
  assign bus16.DIN   = din;
  assign bus16.WR    = wr;
  assign bus16.RD    = rd;
  assign bus16.INTA_ = inta_n;

  pic_controller #(.NUM_IR(8), .SYNC_STAGES(2)) dut8 (
    .CLK       (CLK),
    .RESET_    (RESET_),
    .IR        (ir8),
    .bus       (bus8),
    .INIT_DONE (init_done8)
  );

  pic_controller #(.NUM_IR(16), .SYNC_STAGES(2)) dut16 (
    .CLK       (CLK),
    .RESET_    (RESET_),
    .IR        (ir16),
    .bus       (bus16),
    .INIT_DONE (init_done16)
  );

  always #5 CLK = ~CLK;

  task automatic expect_val(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wr_reg(input logic [1:0] ad, input logic [7:0] d);
    a   = ad;
    din = d;
    wr  = 1'b1;
    tick(1);
    wr  = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] ad, output logic [7:0] r8, output logic [7:0] r16);
    a  = ad;
    rd = 1'b1;
    tick(1);
    r8  = bus8.DOUT;
    r16 = bus16.DOUT;
    rd = 1'b0;
    tick(1);
  endtask

  task automatic wait_int(input bit wide);
    for (int i = 0; i < 30; i++) begin
      if ((wide ? bus16.INT : bus8.INT) === 1'b1) break;
      tick(1);
    end
  endtask

  task automatic inta_pulse(output logic [7:0] o8, output logic [7:0] o16,
                            output logic oe8, output logic oe16);
    inta_n = 1'b0;
    tick(6);
    o8   = bus8.DOUT;
    o16  = bus16.DOUT;
    oe8  = bus8.DOUT_EN;
    oe16 = bus16.DOUT_EN;
    inta_n = 1'b1;
    tick(6);
  endtask

  // Full two-pulse acknowledge; v8/e8 etc. hold what was seen during the second pulse.
  task automatic inta_cycle;
    inta_pulse(v8, v16, e8, e16);
    inta_pulse(v8, v16, e8, e16);
  endtask

  initial begin
    RESET_ = 1'b0;
    ir8 = '0; ir16 = '0; a = '0; din = '0; wr = 1'b0; rd = 1'b0; inta_n = 1'b1;
    tick(3);
    expect_val("rst_int", 16'h0);       check(16'(bus8.INT));
    expect_val("rst_dout_en", 16'h0);   check(16'(bus8.DOUT_EN));
    expect_val("rst_dout", 16'h0);      check(16'(bus8.DOUT));
    expect_val("rst_init_done", 16'h0); check(16'(init_done8));
    RESET_ = 1'b1;
    tick(2);

    // Edge-mode init with IC4, base 0x40
    wr_reg(2'd0, 8'h13);
    wr_reg(2'd1, 8'h40);
    expect_val("init_wait_icw4", 16'h0); check(16'(init_done8));
    wr_reg(2'd1, 8'h01);
    expect_val("init_done", 16'h1);      check(16'(init_done8));

    ir8[3] = 1'b1;
    wait_int(1'b0);
    expect_val("ir3_int", 16'h1);        check(16'(bus8.INT));
    inta_pulse(v8, v16, e8, e16);
    expect_val("ack1_int_drop", 16'h0);  check(16'(bus8.INT));
    inta_pulse(v8, v16, e8, e16);
    expect_val("ir3_vector", 16'h143);   check({7'd0, e8, v8});
    expect_val("vec_release", 16'h0);    check(16'(bus8.DOUT_EN));
    ir8 = '0;
    wr_reg(2'd0, 8'h0B);
    rd_reg(2'd0, d8, d16);
    expect_val("isr_ir3", 16'h08);       check(16'(d8));
    wr_reg(2'd3, 8'h20);
    rd_reg(2'd0, d8, d16);
    expect_val("isr_eoi", 16'h00);       check(16'(d8));

    // Fully nested: IR5 in service, IR2 preempts, IR6 waits
    ir8[5] = 1'b1;
    wait_int(1'b0);
    inta_cycle();
    expect_val("ir5_vector", 16'h145);   check({7'd0, e8, v8});
    ir8 = 8'h44;
    wait_int(1'b0);
    expect_val("nest_int", 16'h1);       check(16'(bus8.INT));
    inta_cycle();
    expect_val("ir2_vector", 16'h142);   check({7'd0, e8, v8});
    ir8 = '0;
    rd_reg(2'd0, d8, d16);
    expect_val("isr_nest", 16'h24);      check(16'(d8));
    wr_reg(2'd3, 8'h20);
    rd_reg(2'd0, d8, d16);
    expect_val("isr_eoi_top", 16'h20);   check(16'(d8));
    tick(3);
    expect_val("ir6_blocked", 16'h0);    check(16'(bus8.INT));
    wr_reg(2'd3, 8'h20);
    wait_int(1'b0);
    expect_val("ir6_int", 16'h1);        check(16'(bus8.INT));
    inta_cycle();
    expect_val("ir6_vector", 16'h146);   check({7'd0, e8, v8});
    wr_reg(2'd3, 8'h20);

    // Rotating priority: LP=4 makes IR5 highest
    wr_reg(2'd3, 8'hC4);
    ir8 = 8'h21;
    wait_int(1'b0);
    inta_cycle();
    expect_val("rot_ir5_vector", 16'h145); check({7'd0, e8, v8});
    ir8 = '0;
    tick(3);
    expect_val("rot_ir0_blocked", 16'h0);  check(16'(bus8.INT));
    wr_reg(2'd3, 8'hA0);
    wait_int(1'b0);
    inta_cycle();
    expect_val("rot_ir0_vector", 16'h140); check({7'd0, e8, v8});
    wr_reg(2'd3, 8'h20);
    wr_reg(2'd3, 8'hC7);

    // Level mode spurious request
    wr_reg(2'd0, 8'h1B);
    wr_reg(2'd1, 8'h40);
    wr_reg(2'd1, 8'h00);
    expect_val("level_init_done", 16'h1); check(16'(init_done8));
    ir8[4] = 1'b1;
    wait_int(1'b0);
    expect_val("level_int", 16'h1);       check(16'(bus8.INT));
    ir8 = '0;
    tick(6);
    expect_val("level_int_drop", 16'h0);  check(16'(bus8.INT));
    inta_cycle();
    expect_val("spurious_vector", 16'h147); check({7'd0, e8, v8});
    wr_reg(2'd0, 8'h0B);
    rd_reg(2'd0, d8, d16);
    expect_val("spurious_isr", 16'h00);   check(16'(d8));

    // AEOI with rotation
    wr_reg(2'd0, 8'h13);
    wr_reg(2'd1, 8'h40);
    wr_reg(2'd1, 8'h03);
    wr_reg(2'd3, 8'h80);
    ir8[1] = 1'b1;
    wait_int(1'b0);
    inta_cycle();
    expect_val("aeoi_ir1_vector", 16'h141); check({7'd0, e8, v8});
    ir8 = '0;
    wr_reg(2'd0, 8'h0B);
    rd_reg(2'd0, d8, d16);
    expect_val("aeoi_isr", 16'h00);       check(16'(d8));
    ir8 = 8'h06;
    wait_int(1'b0);
    inta_cycle();
    expect_val("aeoi_lp1_vector", 16'h142); check({7'd0, e8, v8});
    ir8 = '0;

    // Reset while the vector is being driven (IR1 still pending)
    wait_int(1'b0);
    inta_pulse(v8, v16, e8, e16);
    inta_n = 1'b0;
    tick(6);
    expect_val("ack2_drive", 16'h141);    check({7'd0, bus8.DOUT_EN, bus8.DOUT});
    RESET_ = 1'b0;
    #2;
    expect_val("async_rst_flags", 16'h0); check({13'd0, bus8.INT, bus8.DOUT_EN, init_done8});
    expect_val("async_rst_dout", 16'h0);  check(16'(bus8.DOUT));
    inta_n = 1'b1;
    tick(2);
    RESET_ = 1'b1;
    tick(2);

    // 16-line build: masked IR1, IR15 wins
    wr_reg(2'd0, 8'h13);
    wr_reg(2'd1, 8'h40);
    wr_reg(2'd1, 8'h01);
    wr_reg(2'd1, 8'hFF);
    wr_reg(2'd2, 8'h7F);
    expect_val("w_init_done", 16'h1);     check(16'(init_done16));
    ir16 = 16'h8002;
    wait_int(1'b1);
    expect_val("w_int", 16'h1);           check(16'(bus16.INT));
    wr_reg(2'd0, 8'h0A);
    rd_reg(2'd3, d8, d16);
    expect_val("w_irr_hi", 16'h80);       check(16'(d16));
    expect_val("n_irr_hi_zero", 16'h00);  check(16'(d8));
    rd_reg(2'd1, d8, d16);
    expect_val("w_imr_lo", 16'hFF);       check(16'(d16));
    rd_reg(2'd2, d8, d16);
    expect_val("w_imr_hi", 16'h7F);       check(16'(d16));
    inta_cycle();
    expect_val("w_ir15_vector", 16'h14F); check({7'd0, e16, v16});
    ir16 = '0;
    wr_reg(2'd0, 8'h0B);
    rd_reg(2'd3, d8, d16);
    expect_val("w_isr_hi", 16'h80);       check(16'(d16));
    rd_reg(2'd0, d8, d16);
    expect_val("w_isr_lo", 16'h00);       check(16'(d16));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
